// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Arbitrates register-file writeback between the ALU and the load unit. It
// also keeps a per-register scoreboard of outstanding writes.
//
// Each cycle at most one writeback is accepted. When both requesters are
// valid, the winner is chosen round-robin: the requester that was not granted
// last time wins. An accepted write reaches the register-file write port one
// cycle later, through registered outputs. Writes to x0 are accepted but
// discarded.
//
// The issue stage reserves a destination register by setting its pending
// bit. An accepted write clears that bit. If a write is accepted for a
// non-zero register that was not pending, the sticky err_unreserved flag is
// set.
//
// Ports
//   clk, reset_n                     clock, async active-low reset
//   alu_valid/addr/data, alu_ready   ALU writeback request / accept
//   lsu_valid/addr/data, lsu_ready   load-unit writeback request / accept
//   reserve_valid, reserve_addr      scoreboard reservation from issue
//   rf_write_enable/addr/data        registered register-file write port
//   pending                          scoreboard bitmap, bit n = xn outstanding
//   err_unreserved                   sticky unreserved-write flag
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       alu_valid,
  input  logic [ADDR_WIDTH-1:0]      alu_addr,
  input  logic [DATA_WIDTH-1:0]      alu_data,
  output logic                       alu_ready,
  input  logic                       lsu_valid,
  input  logic [ADDR_WIDTH-1:0]      lsu_addr,
  input  logic [DATA_WIDTH-1:0]      lsu_data,
  output logic                       lsu_ready,
  input  logic                       reserve_valid,
  input  logic [ADDR_WIDTH-1:0]      reserve_addr,
  output logic                       rf_write_enable,
  output logic [ADDR_WIDTH-1:0]      rf_write_addr,
  output logic [DATA_WIDTH-1:0]      rf_write_data,
  output logic [(2**ADDR_WIDTH)-1:0] pending,
  output logic                       err_unreserved
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;

  grant_e                  last_grant_q, last_grant_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0]     pending_q, pending_d;
  logic                    err_q, err_d;

  logic                    grant_alu, grant_lsu, accept;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [DATA_WIDTH-1:0]   acc_data;
  logic                    acc_nonzero;

  // Under contention, the requester that was not served last wins. Gating the
  // grants with reset_n keeps both ready outputs low while reset is held.
  assign grant_alu = reset_n && alu_valid && (!lsu_valid || last_grant_q == GRANT_LSU);
  assign grant_lsu = reset_n && lsu_valid && (!alu_valid || last_grant_q == GRANT_ALU);
  assign accept    = grant_alu || grant_lsu;

  assign alu_ready = grant_alu;
  assign lsu_ready = grant_lsu;

  assign acc_addr    = grant_alu ? alu_addr : lsu_addr;
  assign acc_data    = grant_alu ? alu_data : lsu_data;
  assign acc_nonzero = accept && (acc_addr != '0);

  always_comb begin
    // NOTE: every signal gets a default here first, so no path leaves a value
    // unassigned and no latch is inferred.
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    pending_d    = pending_q;
    err_d        = err_q;

    if (accept) begin
      last_grant_d = grant_alu ? GRANT_ALU : GRANT_LSU;
    end

    // A write to x0 is accepted but discarded. Address and data are loaded
    // only for a real write, so they hold across idle and x0 cycles.
    if (acc_nonzero) begin
      wr_en_d   = 1'b1;
      wr_addr_d = acc_addr;
      wr_data_d = acc_data;
      pending_d[acc_addr] = 1'b0;
      if (!pending_q[acc_addr]) begin
        err_d = 1'b1;
      end
    end

    // The set is applied after the clear. A reservation on the same edge
    // comes from a younger instruction, so it must survive.
    if (reserve_valid && reserve_addr != '0) begin
      pending_d[reserve_addr] = 1'b1;
    end

    pending_d[0] = 1'b0;
  end

  // NOTE: the storage here is a flat bitmap of flops, not a RAM, so every
  // register can be cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= GRANT_LSU;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      pending_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the pre-edge
      // values no matter how the statements are ordered.
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      pending_q    <= pending_d;
      err_q        <= err_d;
    end
  end

  assign rf_write_enable = wr_en_q;
  assign rf_write_addr   = wr_addr_q;
  assign rf_write_data   = wr_data_q;
  assign pending         = pending_q;
  assign err_unreserved  = err_q;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of write data.
REQ-002 Parameter ADDR_WIDTH, default 5: register address width; 2**ADDR_WIDTH registers.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 alu_valid  input  1  ALU writeback request.
REQ-006 alu_addr  input  ADDR_WIDTH  ALU destination register.
REQ-007 alu_data  input  DATA_WIDTH  ALU result.
REQ-008 alu_ready  output  1  ALU request accepted this cycle.
REQ-009 lsu_valid  input  1  load-unit writeback request.
REQ-010 lsu_addr  input  ADDR_WIDTH  load destination register.
REQ-011 lsu_data  input  DATA_WIDTH  load result.
REQ-012 lsu_ready  output  1  load request accepted this cycle.
REQ-013 reserve_valid  input  1  issue stage marks a destination as pending.
REQ-014 reserve_addr  input  ADDR_WIDTH  register being reserved.
REQ-015 rf_write_enable  output  1  register file write enable, registered.
REQ-016 rf_write_addr  output  ADDR_WIDTH  register file write address, registered.
REQ-017 rf_write_data  output  DATA_WIDTH  register file write data, registered.
REQ-018 pending  output  2**ADDR_WIDTH  scoreboard bitmap; bit n = write to xn outstanding.
REQ-019 err_unreserved  output  1  sticky: a write was accepted to a non-pending, non-zero register.

Function
REQ-020 At most one request is accepted per cycle; a transfer occurs when valid && ready on the same port.
REQ-021 ready outputs are combinational from valid inputs and the priority pointer; ready is never asserted without the matching valid.
REQ-022 Only one requester valid -> that requester gets ready=1.
REQ-023 Both valid -> round-robin: grant goes to the requester NOT granted last; last_grant is a one-bit register.
REQ-024 last_grant updates only on an accepted transfer; it is unchanged in idle cycles.
REQ-025 Requesters hold valid/addr/data stable until accepted; the arbiter does not buffer unaccepted requests.
REQ-026 Latency: a transfer accepted at edge N drives rf_write_enable=1 with its addr/data for the cycle after edge N, causing the register file write at edge N+1.
REQ-027 No transfer at edge N -> rf_write_enable=0 after edge N; rf_write_addr/rf_write_data hold their previous values.
REQ-028 Transfer with addr 0 -> accepted (ready=1), but rf_write_enable stays 0; x0 writes are discarded.
REQ-029 reserve_valid with reserve_addr != 0 sets pending[reserve_addr] at the next edge.
REQ-030 An accepted transfer to addr != 0 clears pending[addr] at the same edge the output register loads.
REQ-031 Same-edge set and clear of the same bit -> set wins; this is a new reservation by a younger instruction.
REQ-032 Same-edge set and clear of different bits -> both take effect.
REQ-033 pending[0] is constant 0; reservations of x0 are ignored.
REQ-034 An accepted transfer to addr != 0 with pending[addr]=0 (pre-edge value) sets err_unreserved at that edge; the write still occurs; err_unreserved clears only on reset.

Reset
REQ-035 reset_n=0 asynchronously forces rf_write_enable=0, rf_write_addr=0, rf_write_data=0, pending=0, err_unreserved=0, last_grant=LSU, so the ALU wins the first contention.
REQ-036 While reset_n=0, alu_ready=0 and lsu_ready=0 regardless of valids.
REQ-037 Reset asserted with a write pending in the output register -> that write is dropped (rf_write_enable=0 immediately).
REQ-038 Deassertion takes effect at the first rising edge with reset_n=1.

Verification
REQ-039 After reset, reserve x5, then alu_valid with addr 5, data 0xAAAAAAAA -> alu_ready=1; next cycle rf_write_enable=1, addr 5, data 0xAAAAAAAA; pending[5]=0; err_unreserved=0.
REQ-040 Reserve x1 and x2, then both valid for 4 cycles (ALU addr 1 data 0x11111111, LSU addr 2 data 0x22222222, each dropping valid once accepted) -> grant ALU first, then LSU; outputs are addr 1 then addr 2 on consecutive cycles.
REQ-041 Both valid continuously with new data each accept -> grants strictly alternate ALU, LSU, ALU, LSU.
REQ-042 lsu_valid, addr 0, data 0x12345678 -> lsu_ready=1; rf_write_enable stays 0; pending unchanged; err_unreserved=0.
REQ-043 pending[3]=1; reserve x3 in the same cycle as ALU write to x3 -> pending[3]=1 after the edge; rf writes x3.
REQ-044 ALU write to x7 without reservation -> write occurs and err_unreserved=1 thereafter; assert reset_n=0 mid-cycle -> all outputs 0 immediately.
